fifo_push_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the 8-input router FIFO among 8 requesters.
- Guarantees at most one push per cycle and zero data on all non-granted lanes, so the FIFO's OR-combined push/din inputs are always clean.
- Supports packet bursts: an owner keeps the grant until it flags its last word, hits a burst limit, or withdraws its request.
- Sits between the router input ports and the FIFO write side; it consumes the FIFO full flag.

---
 rtl/fifo_push_arbiter.sv | 172 +++++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
//
// Round-robin arbiter that shares the single write port of the router FIFO
// among NREQ requesters. A granted owner keeps the port for a packet burst
// until it flags its last word, reaches MAXBURST accepted words, or drops its
// request. At most one push bit is ever high, and every non-pushing lane of
// dout is driven to zero, so the FIFO can OR-combine push/din safely.
//
// Optional build macro: FIFO_PUSH_ARB_STATS_EN
//   defined     -> stall_cnt counts owner cycles lost to fifo_full (saturating)
//   not defined -> stall_cnt is tied to zero and no counter flops exist
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
   parameter int NREQ     = 8,
   parameter int DW       = 32,
   parameter int MAXBURST = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      last,
   input  logic [NREQ*DW-1:0]   din,
   input  logic                 fifo_full,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      push,
   output logic [NREQ*DW-1:0]   dout,
   output logic [15:0]          stall_cnt
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   // Registered arbitration state
   state_t            r_state;
   logic [IW-1:0]     r_owner;
   logic [IW-1:0]     r_ptr;
   logic [3:0]        r_beat_cnt;
   logic [NREQ-1:0]   r_gnt;

   // Combinational decode of the current cycle
   logic              w_own;
   logic              w_owner_req;
   logic              w_owner_last;
   logic              w_accept;
   logic              w_burst_end;
   logic              w_release;
   logic [IW-1:0]     w_next_ptr;
   logic [NREQ-1:0]   w_owner_dec;
   logic [NREQ-1:0]   w_mask;
   logic [NREQ-1:0]   w_search_req;
   logic [IW-1:0]     w_search_ptr;
   logic              w_pick_found;
   logic [IW-1:0]     w_pick_idx;
   logic [IW-1:0]     w_scan_idx;
   logic [NREQ-1:0]   w_pick_dec;

   assign w_own        = (r_state == ST_OWN);
   assign w_owner_req  = req[r_owner];
   assign w_owner_last = last[r_owner];

   // A word moves only when the owner presents one and the FIFO has room.
   assign w_accept     = w_own & w_owner_req & ~fifo_full;
   assign w_burst_end  = (r_beat_cnt == 4'(MAXBURST - 1));

   // Last-word and burst-limit releases need an accept, so a full FIFO holds
   // the grant; a withdrawn request releases regardless of fifo_full.
   assign w_release    = w_own & ((w_accept & (w_owner_last | w_burst_end)) | ~w_owner_req);

   assign w_next_ptr   = r_owner + IW'(1);

   // The owner whose packet just ended is removed from the re-pick so its
   // still-high req does not win the port back in the same cycle. After a
   // burst-limit release it stays eligible, but since the scan starts at
   // owner+1 it is only chosen when nobody else is requesting.
   assign w_mask       = (w_accept & w_owner_last) ? w_owner_dec : '0;
   assign w_search_req = req & ~w_mask;
   assign w_search_ptr = w_own ? w_next_ptr : r_ptr;

   // Per-lane decode and output gating
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign w_owner_dec[gi]        = (r_owner == IW'(gi));
      assign w_pick_dec[gi]         = (w_pick_idx == IW'(gi));
      assign push[gi]               = w_accept & r_gnt[gi];
      assign dout[gi*DW +: DW]      = (w_accept & r_gnt[gi]) ? din[gi*DW +: DW] : '0;
   end

   assign gnt = r_gnt;

   // Round-robin pick: first requester at search_ptr, search_ptr+1, ... (mod NREQ).
   // Scanned from the farthest offset down so the nearest hit is written last.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      w_scan_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_scan_idx = w_search_ptr + IW'(k);
         if (w_search_req[w_scan_idx]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_scan_idx;
         end
      end
   end

   // Arbitration FSM: grant, owner, search pointer and beat counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_owner    <= '0;
         r_ptr      <= '0;
         r_beat_cnt <= '0;
         r_gnt      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_found) begin
                  r_state    <= ST_OWN;
                  r_owner    <= w_pick_idx;
                  r_beat_cnt <= '0;
                  r_gnt      <= w_pick_dec;
               end
            end
            ST_OWN: begin
               if (w_release) begin
                  r_ptr <= w_next_ptr;
                  if (w_pick_found) begin
                     // Hand over directly, no idle bubble between owners.
                     r_owner    <= w_pick_idx;
                     r_beat_cnt <= '0;
                     r_gnt      <= w_pick_dec;
                  end else begin
                     r_state    <= ST_IDLE;
                     r_beat_cnt <= '0;
                     r_gnt      <= '0;
                  end
               end else if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + 4'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

`ifdef FIFO_PUSH_ARB_STATS_EN
   logic [15:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = w_own & w_owner_req & fifo_full;

   // Saturating count of cycles where the owner had a word but the FIFO was full.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_push_arbiter
//
// Directed bench for fifo_push_arbiter. Inputs are driven at posedge+1 and
// outputs are compared at posedge+2, so registered gnt reflects the last edge
// and combinational push/dout reflect the inputs of the current cycle.
// Lane i carries the word {i+1, tag} so every lane value is distinct.
// -----------------------------------------------------------------------------
module tb_fifo_push_arbiter;

   localparam int NREQ = 8;
   localparam int DW   = 32;
   localparam int W    = NREQ * DW;

`ifdef FIFO_PUSH_ARB_STATS_EN
   localparam logic [15:0] EXP_STALL = 16'd5;
`else
   localparam logic [15:0] EXP_STALL = 16'd0;
`endif

   logic              clk;
   logic              resetn;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   last;
   logic [W-1:0]      din;
   logic              fifo_full;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   push;
   logic [W-1:0]      dout;
   logic [15:0]       stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   fifo_push_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBURST(4)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .last      (last),
      .din       (din),
      .fifo_full (fifo_full),
      .gnt       (gnt),
      .push      (push),
      .dout      (dout),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] lane_word(input int i, input int tag);
      return {4'(i + 1), 28'(tag)};
   endfunction

   function automatic logic [W-1:0] exp_dout(input int g, input int tag);
      logic [W-1:0] v;
      v = '0;
      v[g*DW +: DW] = lane_word(g, tag);
      return v;
   endfunction

   task automatic set_din(input int tag);
      for (int i = 0; i < NREQ; i++) din[i*DW +: DW] = lane_word(i, tag);
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn    = 1'b0;
      req       = '0;
      last      = '0;
      fifo_full = 1'b0;
      set_din(0);

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt",   W'(gnt),       '0);
      chk("rst_push",  W'(push),      '0);
      chk("rst_dout",  dout,          '0);
      chk("rst_stall", W'(stall_cnt), '0);
      #2 resetn = 1'b1;

      // ---------------- all 8, single-word packets ----------------
      req  = 8'hFF;
      last = 8'hFF;
      #1;
      chk("rr_latency_gnt", W'(gnt), '0);
      tick();
      for (int k = 0; k < 9; k++) begin
         set_din(k);
         #1;
         chk($sformatf("rr_gnt_%0d", k),  W'(gnt),  W'(8'h01 << (k % 8)));
         chk($sformatf("rr_push_%0d", k), W'(push), W'(8'h01 << (k % 8)));
         chk($sformatf("rr_dout_%0d", k), dout,     exp_dout(k % 8, k));
         if (k == 8) begin
            req  = '0;
            last = '0;
         end
         tick();
      end
      #1;
      chk("rr_idle_gnt", W'(gnt), '0);

      // ---------------- single requester, 3 words ----------------
      req = 8'h04;
      set_din(1);
      #1;
      chk("single_latency_gnt", W'(gnt),  '0);
      chk("single_latency_push", W'(push), '0);
      tick();
      for (int w = 1; w <= 3; w++) begin
         set_din(w);
         if (w == 3) last = 8'h04;
         #1;
         chk($sformatf("single_gnt_%0d", w),  W'(gnt),  W'(8'h04));
         chk($sformatf("single_push_%0d", w), W'(push), W'(8'h04));
         chk($sformatf("single_dout_%0d", w), dout,     exp_dout(2, w));
         tick();
      end
      req  = '0;
      last = '0;
      #1;
      chk("single_end_gnt",  W'(gnt),  '0);
      chk("single_end_push", W'(push), '0);
      chk("single_end_dout", dout,     '0);

      // ---------------- MAXBURST alternation ----------------
      req = 8'h03;
      tick();
      for (int k = 0; k < 9; k++) begin
         set_din(100 + k);
         #1;
         chk($sformatf("burst_gnt_%0d", k),  W'(gnt),  W'((k >= 4 && k < 8) ? 8'h02 : 8'h01));
         chk($sformatf("burst_push_%0d", k), W'(push), W'((k >= 4 && k < 8) ? 8'h02 : 8'h01));
         chk($sformatf("burst_dout_%0d", k), dout,     exp_dout((k >= 4 && k < 8) ? 1 : 0, 100 + k));
         tick();
      end

      // ---------------- back-pressure, owner 0 after one word ----------------
      fifo_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_din(200 + k);
         #1;
         chk($sformatf("full_gnt_%0d", k),  W'(gnt),  W'(8'h01));
         chk($sformatf("full_push_%0d", k), W'(push), '0);
         chk($sformatf("full_dout_%0d", k), dout,     '0);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      chk("full_stall_cnt", W'(stall_cnt), W'(EXP_STALL));
      for (int k = 0; k < 3; k++) begin
         set_din(300 + k);
         #1;
         chk($sformatf("resume_push_%0d", k), W'(push), W'(8'h01));
         chk($sformatf("resume_dout_%0d", k), dout,     exp_dout(0, 300 + k));
         tick();
      end
      #1;
      chk("resume_handover_gnt", W'(gnt), W'(8'h02));
      req = '0;
      tick();
      chk("resume_idle_gnt", W'(gnt), '0);

      // ---------------- withdrawal of owner 3 ----------------
      req = 8'h08;
      tick();
      set_din(400);
      #1;
      chk("wd_gnt_0",  W'(gnt),  W'(8'h08));
      chk("wd_push_0", W'(push), W'(8'h08));
      tick();
      req = 8'h48;
      #1;
      chk("wd_push_1", W'(push), W'(8'h08));
      tick();
      req = 8'h40;
      #1;
      chk("wd_drop_gnt",  W'(gnt),  W'(8'h08));
      chk("wd_drop_push", W'(push), '0);
      chk("wd_drop_dout", dout,     '0);
      tick();
      set_din(402);
      #1;
      chk("wd_new_gnt",  W'(gnt),  W'(8'h40));
      chk("wd_new_push", W'(push), W'(8'h40));
      chk("wd_new_dout", dout,     exp_dout(6, 402));

      // ---------------- asynchronous reset mid-burst ----------------
      #2 resetn = 1'b0;
      #1;
      chk("arst_gnt",   W'(gnt),       '0);
      chk("arst_push",  W'(push),      '0);
      chk("arst_dout",  dout,          '0);
      chk("arst_stall", W'(stall_cnt), '0);
      req = 8'h80;
      tick();
      chk("arst_held_gnt", W'(gnt), '0);
      #2 resetn = 1'b1;
      #1;
      chk("arst_rel_gnt", W'(gnt), '0);
      tick();
      set_din(500);
      #1;
      chk("arst_first_gnt",  W'(gnt),  W'(8'h80));
      chk("arst_first_push", W'(push), W'(8'h80));
      chk("arst_first_dout", dout,     exp_dout(7, 500));
      req = '0;
      tick();
      chk("final_idle_gnt", W'(gnt), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
